// File: rtl/fetch_inst_queue.sv
// Fetch front end: owns the fetch PC and queues FETCH_WIDTH tagged words per fetch; decode drains up to DEQ_WIDTH per cycle.
// One cycle from fetch to a visible deq lane; fetch stalls when free space < FETCH_WIDTH (no pop-to-push bypass).
module fetch_inst_queue #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int FETCH_WIDTH     = 2,
    parameter int DEQ_WIDTH       = 2,
    parameter int QUEUE_DEPTH     = 8,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    output logic [INST_ADDR_WIDTH-1:0]                    pc_o,
    input  logic [FETCH_WIDTH-1:0][31:0]                  inst_i,
    input  logic                                          stall,
    input  logic                                          redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0]                    redirect_pc,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]                deq_req,
    output logic [DEQ_WIDTH-1:0]                          deq_valid,
    output logic [DEQ_WIDTH-1:0][31:0]                    deq_inst,
    output logic [DEQ_WIDTH-1:0][INST_ADDR_WIDTH-1:0]     deq_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]              count,
    output logic                                          empty
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
    localparam int AW    = INST_ADDR_WIDTH;

    logic [AW-1:0]    r_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_inst_mem [QUEUE_DEPTH];
    logic [AW-1:0]    r_pc_mem   [QUEUE_DEPTH];

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_req;
    logic [CNT_W-1:0] w_pops;
    logic [CNT_W-1:0] w_push_cnt;
    logic             w_fetch_en;

    // Free space uses the pre-pop count, so a full queue waits one cycle after a drain.
    assign w_free     = CNT_W'(QUEUE_DEPTH) - r_count;
    assign w_fetch_en = !redirect_valid && !stall && (w_free >= CNT_W'(FETCH_WIDTH));
    assign w_req      = CNT_W'(deq_req);
    assign w_pops     = (w_req > r_count) ? r_count : w_req;
    assign w_push_cnt = w_fetch_en ? CNT_W'(FETCH_WIDTH) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc & ~AW'(3);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fetch_en) begin
                r_tail <= r_tail + PTR_W'(FETCH_WIDTH);
                r_pc   <= r_pc + AW'(4 * FETCH_WIDTH);
            end
            r_head  <= r_head + w_pops[PTR_W-1:0];
            r_count <= r_count + w_push_cnt - w_pops;
        end
    end

    // Storage has no reset; entries are only observable through valid lanes.
    always_ff @(posedge clk) begin
        if (reset && w_fetch_en) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                r_inst_mem[r_tail + PTR_W'(k)] <= inst_i[k];
                r_pc_mem[r_tail + PTR_W'(k)]   <= r_pc + AW'(4 * k);
            end
        end
    end

    for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_lane
        logic [PTR_W-1:0] w_idx;
        assign w_idx        = r_head + PTR_W'(g);
        assign deq_valid[g] = (r_count > CNT_W'(g));
        assign deq_inst[g]  = deq_valid[g] ? r_inst_mem[w_idx] : 32'd0;
        assign deq_pc[g]    = deq_valid[g] ? r_pc_mem[w_idx] : '0;
    end

    assign pc_o  = r_pc;
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule
